alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter WDOG_LIMIT, default 32, watchdog cycle limit (used only per REQ-030).
REQ-003 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port req  input  N_REQ  per-requester request level, held until gnt.
REQ-006 SHALL provide port req_a  input  16*N_REQ  operand A; requester i at bits [16i+15:16i].
REQ-007 SHALL provide port req_b  input  16*N_REQ  operand B, same packing.
REQ-008 SHALL provide port req_op  input  4*N_REQ  opcode, [4i+3:4i].
REQ-009 SHALL provide port gnt  output  N_REQ  one-hot, one-cycle pulse; operands accepted.
REQ-010 SHALL provide port done  output  N_REQ  one-hot, one-cycle pulse; res valid.
REQ-011 SHALL provide port res  output  16  result of the completed operation, held until next done.
REQ-012 SHALL provide port err  output  1  one-cycle pulse coincident with done on watchdog abort.
REQ-013 SHALL provide ports alu_a, alu_b  output  16; alu_opcode  output  4; alu_start  output  1  to the ALU.
REQ-014 SHALL provide ports alu_result  input  16; alu_busy  input  1  from the ALU.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT.
REQ-016 IDLE: when any req bit set and alu_busy low, SHALL select winner round-robin, searching upward from pointer ptr with wrap, latch its A/B/op, and enter ISSUE.
REQ-017 IDLE with alu_busy high SHALL grant nothing.
REQ-018 ISSUE: gnt[winner]=1 and alu_start=1 for exactly this cycle, then enter WAIT.
REQ-019 alu_a/alu_b/alu_opcode SHALL be driven from the latched registers, stable from ISSUE through the last WAIT cycle; the ALU samples them at completion of MUL/DIV.
REQ-020 WAIT: on first cycle with alu_busy low, SHALL register res<=alu_result, done[winner]<=1 next cycle, set ptr<=(winner+1) mod N_REQ, and return to IDLE.
REQ-021 Latency req-rise (IDLE) to done: opcodes 0000-0111 = 3 cycles; 1000 (MUL) = 8; 1001 (DIV) = 12.
REQ-022 Opcodes 1010-1111: alu_start SHALL stay low in ISSUE; completion as REQ-020 with res=0.
REQ-023 The IDLE cycle in which done pulses SHALL be able to arbitrate; back-to-back service SHALL have no dead cycle beyond REQ-021.
REQ-024 A requester dropping req before gnt SHALL be withdrawn without side effect; req sampled only in IDLE.
REQ-025 At most one gnt bit and one done bit SHALL be set in any cycle; gnt and done never target different outstanding operations.
REQ-026 res SHALL be 16-bit truncated ALU output; no widening.

Reset
REQ-027 rst high at a clock edge SHALL force state=IDLE, ptr=0, gnt=0, done=0, err=0, res=0, alu_start=0, latched A/B/op=0.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse; requester re-requests.
REQ-029 First request after reset SHALL be served from index 0 upward.

Configuration
REQ-030 Macro ALU_ARB_WDOG_EN defined: a WAIT-cycle counter SHALL abort when WDOG_LIMIT consecutive WAIT cycles elapse with alu_busy high, producing done[winner], err=1, res=0, return to IDLE.
REQ-031 Macro ALU_ARB_WDOG_EN undefined: no counter; WAIT persists until alu_busy low; err tied 0.

Verification
REQ-032 Single req[0], A=5, B=3, op=0000 -> gnt[0] cycle 1, done[0] cycle 3, res=8.
REQ-033 req[1], A=300, B=200, op=1000 -> done[1] 8 cycles after request, res=60000 (16'hEA60).
REQ-034 req[2], A=100, B=0, op=1001 -> done[2] at cycle 12, res=0; then A=100, B=7 -> res=14.
REQ-035 req=4'b1111 all op 0000 held continuously from reset -> grant order 0,1,2,3,0, one done per 3-cycle window except back-to-back overlap per REQ-023.
REQ-036 rst asserted during MUL WAIT -> no done; all outputs 0 next cycle; op 1100 afterward -> done with res=0, alu_start never high.
REQ-037 With ALU_ARB_WDOG_EN, alu_busy forced high 40 cycles -> done and err at WAIT cycle 32, res=0; without macro, done only after busy falls.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle ALU among N_REQ requesters.
// Define ALU_ARB_WDOG_EN to enable the WAIT-state watchdog abort (err pulse).
module alu_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned WDOG_LIMIT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    input  logic [4*N_REQ-1:0]    req_op,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           res,
    output logic                  err,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_opcode,
    output logic                  alu_start,
    input  logic [15:0]           alu_result,
    input  logic                  alu_busy
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d, win_nxt, sel;
    logic [15:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             op_valid, found;
    int unsigned      idx;

    logic [15:0] ra [N_REQ];
    logic [15:0] rb [N_REQ];
    logic [3:0]  ro [N_REQ];

    if (N_REQ < 2 || N_REQ > 8 || WDOG_LIMIT < 1) begin : g_bad_cfg
        $error("alu_arbiter: unsupported N_REQ or WDOG_LIMIT");
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign ra[g] = req_a[16*g +: 16];
        assign rb[g] = req_b[16*g +: 16];
        assign ro[g] = req_op[4*g +: 4];
    end

    // Opcodes above DIV are not ALU operations: no start, result forced to zero.
    assign op_valid = (op_q <= 4'd9);
    assign win_nxt  = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef ALU_ARB_WDOG_EN
    localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d, wdog_fire;

    assign wdog_fire = (state_q == WAIT) && alu_busy && (wcnt_q == CW'(WDOG_LIMIT - 1));
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        done_d    = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        gnt       = '0;
        alu_start = 1'b0;
`ifdef ALU_ARB_WDOG_EN
        wcnt_d    = '0;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!alu_busy) begin
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        idx = k + ptr_q;
                        if (idx >= N_REQ) idx = idx - N_REQ;
                        sel = idx[PW-1:0];
                        if (!found && req[sel]) begin
                            found = 1'b1;
                            win_d = sel;
                            a_d   = ra[sel];
                            b_d   = rb[sel];
                            op_d  = ro[sel];
                        end
                    end
                    if (found) state_d = ISSUE;
                end
            end
            ISSUE: begin
                gnt[win_q] = 1'b1;
                alu_start  = op_valid;
                state_d    = WAIT;
            end
            WAIT: begin
                if (!alu_busy) begin
                    res_d         = op_valid ? alu_result : '0;
                    done_d[win_q] = 1'b1;
                    ptr_d         = win_nxt;
                    state_d       = IDLE;
                end
`ifdef ALU_ARB_WDOG_EN
                else if (wdog_fire) begin
                    res_d         = '0;
                    done_d[win_q] = 1'b1;
                    err_d         = 1'b1;
                    ptr_d         = win_nxt;
                    state_d       = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            done_q  <= '0;
`ifdef ALU_ARB_WDOG_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= done_d;
`ifdef ALU_ARB_WDOG_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign done       = done_q;
    assign res        = res_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;

endmodule
